mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and scheduler that shares one 4:1 4-bit mux datapath among four valid/ready requesters.
- Generates the 2-bit mux select.
- Registers the selected beat into a single output stage with a valid/ready handshake.
- Supports bounded bursts: a granted requester keeps the channel for up to MAX_BURST consecutive beats before priority rotates.

---
 rtl/mux4_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 WIDTH-bit mux among four
//               valid/ready requesters. The selected beat is registered into a
//               single output stage with a valid/ready handshake. An owner may
//               keep the channel for up to MAX_BURST consecutive beats before
//               priority rotates past it.
// Ports       :
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   4        per-requester valid (bit i = requester i)
//   in_data    in   4*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
//   in_ready   out  4        per-requester ready, one-hot or zero
//   out_valid  out  1        output beat valid
//   out_data   out  WIDTH    output beat data
//   out_src    out  2        requester index that produced out_data
//   out_ready  in   1        downstream accepts output beat
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  // Registered state
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_src;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_owner;
  logic [3:0]       r_burst_cnt;
  logic             r_owner_active;

  // Combinational
  logic             w_load_en;
  logic             w_drop;
  logic             w_keep;
  logic [1:0]       w_ptr;
  logic             w_found;
  logic [1:0]       w_scan;
  logic [1:0]       w_idx;
  logic             w_has_winner;
  logic [1:0]       w_winner;
  logic             w_accept;
  logic [3:0]       w_cnt_next;
  logic [WIDTH-1:0] w_sel_data;

  assign w_load_en = !r_out_valid || out_ready;

  // The owner leaving the bus is observed whenever the output stage can load;
  // the scan then starts just past the old owner in the same cycle.
  assign w_drop = w_load_en && r_owner_active && !in_valid[r_owner];
  assign w_ptr  = w_drop ? (r_owner + 2'd1) : r_rr_ptr;
  assign w_keep = r_owner_active && in_valid[r_owner] && (r_burst_cnt < c_max_burst);

  // Rotating priority scan starting at w_ptr.
  always_comb begin
    w_found = 1'b0;
    w_scan  = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_ptr + 2'(k);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_scan  = w_idx;
      end
    end
  end

  assign w_winner     = w_keep ? r_owner : w_scan;
  assign w_has_winner = w_keep || w_found;
  assign w_accept     = w_load_en && w_has_winner;

  // Ready is forced low while reset is held, independent of register state.
  assign in_ready = (rst_n && w_accept) ? (4'b0001 << w_winner) : 4'b0000;

  // Beat count after this accept: continue the burst or start a new one.
  assign w_cnt_next = (r_owner_active && (w_winner == r_owner)) ?
                      (r_burst_cnt + 4'd1) : 4'd1;

  // 4:1 datapath mux driven by the winner index.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_winner == 2'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_src      <= 2'd0;
      r_rr_ptr       <= 2'd0;
      r_owner        <= 2'd0;
      r_burst_cnt    <= 4'd0;
      r_owner_active <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data <= w_sel_data;
        r_out_src  <= w_winner;
        r_owner    <= w_winner;
        if (w_cnt_next == c_max_burst) begin
          // Burst exhausted: release ownership and rotate past the winner.
          r_owner_active <= 1'b0;
          r_burst_cnt    <= 4'd0;
          r_rr_ptr       <= w_winner + 2'd1;
        end else begin
          r_owner_active <= 1'b1;
          r_burst_cnt    <= w_cnt_next;
          if (w_drop) begin
            r_rr_ptr <= r_owner + 2'd1;
          end
        end
      end else if (w_drop) begin
        r_owner_active <= 1'b0;
        r_burst_cnt    <= 4'd0;
        r_rr_ptr       <= r_owner + 2'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Directed self-checking bench for mux4_rr_arbiter. One instance
//               uses MAX_BURST=4, a second uses MAX_BURST=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  logic [3:0]  in_valid1;
  logic [15:0] in_data1;
  logic [3:0]  in_ready1;
  logic        out_valid1;
  logic [3:0]  out_data1;
  logic [1:0]  out_src1;
  logic        out_ready1;

  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_src(out_src1), .out_ready(out_ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One accepted beat on the MAX_BURST=4 instance: ready before the edge,
  // registered output after it.
  task automatic beat4(input string tag, input logic [1:0] s, input logic [3:0] d);
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'(4'b0001 << s));
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_src"}, 32'(out_src), 32'(s));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
  endtask

  task automatic beat1(input string tag, input logic [1:0] s);
    #1;
    chk({tag, "_ready"}, 32'(in_ready1), 32'(4'b0001 << s));
    tick();
    chk({tag, "_valid"}, 32'(out_valid1), 32'd1);
    chk({tag, "_src"}, 32'(out_src1), 32'(s));
    chk({tag, "_data"}, 32'(out_data1), 32'(4'(s) + 4'd5));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 4'hF;
    in_data    = 16'h8765;
    out_ready  = 1'b0;
    in_valid1  = 4'h0;
    in_data1   = 16'h8765;
    out_ready1 = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_src", 32'(out_src), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);

    // Single requester 2 with data 0xA; five beats span a forced rotation.
    rst_n     = 1'b1;
    in_valid  = 4'b0100;
    in_data   = 16'h8A65;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) beat4("single", 2'd2, 4'hA);
    in_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(in_ready), 32'd0);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data_hold", 32'(out_data), 32'hA);
    chk("idle_src_hold", 32'(out_src), 32'd2);

    // All four valid: bursts of four rotating 0,1,2,3, then back to 0.
    do_reset("pre_all");
    in_data  = 16'h8765;
    in_valid = 4'hF;
    for (int k = 0; k < 17; k++) beat4("allfour", 2'((k / 4) % 4), 4'(((k / 4) % 4) + 5));

    // Backpressure: output holds, nobody is ready, burst count preserved.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h5);
      chk("bp_src", 32'(out_src), 32'd0);
    end
    out_ready = 1'b1;
    beat4("bp_rel", 2'd0, 4'h5);
    beat4("bp_rel", 2'd0, 4'h5);
    beat4("bp_rel", 2'd0, 4'h5);
    beat4("bp_rel", 2'd1, 4'h6);

    // Early release: req0 drops after two beats, req1 wins the same cycle.
    do_reset("pre_early");
    in_valid = 4'b0011;
    beat4("early", 2'd0, 4'h5);
    beat4("early", 2'd0, 4'h5);
    in_valid = 4'b0010;
    beat4("early_sw", 2'd1, 4'h6);
    in_valid = 4'b0011;
    beat4("early_b", 2'd1, 4'h6);
    beat4("early_b", 2'd1, 4'h6);
    beat4("early_b", 2'd1, 4'h6);
    beat4("early_b", 2'd0, 4'h5);

    // Reset mid-burst with owner=3, burst_cnt=2.
    do_reset("pre_mid");
    in_valid = 4'b1000;
    beat4("mid", 2'd3, 4'h8);
    beat4("mid", 2'd3, 4'h8);
    in_valid = 4'b1010;
    do_reset("mid");
    beat4("post_rst", 2'd1, 4'h6);

    // MAX_BURST=1: per-beat round robin and pointer wrap.
    in_valid1  = 4'b1010;
    out_ready1 = 1'b1;
    beat1("rr1", 2'd1);
    beat1("rr1", 2'd3);
    beat1("rr1", 2'd1);
    beat1("rr1", 2'd3);
    in_valid1 = 4'b1011;
    beat1("wrap", 2'd0);
    beat1("wrap", 2'd1);
    beat1("wrap", 2'd3);
    beat1("wrap", 2'd0);
    beat1("wrap", 2'd1);
    beat1("wrap", 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
